uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 56 +++++
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
//==============================================================================
// Module : uart_arb_pkg
// Brief  : Shared encodings and widths for the UART transmit arbiter.
//          - state_t : arbiter FSM state encoding
//          - ID_W    : width of a requester index
//          - BYTE_W  : width of one transmitted byte
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package uart_arb_pkg;

    localparam int ID_W   = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
//==============================================================================
// Module : uart_rr_pick
// Brief  : Combinational round-robin picker. The search starts one position
//          after the last granted requester and wraps around.
// Ports  : req_i      in  N_REQ  request vector
//          last_gnt_i in  ID_W   index of the previous winner
//          valid_o    out 1      at least one request is pending
//          winner_o   out ID_W   index of the selected requester
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_gnt_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  winner_o
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W:0]      w_start;
    int                 w_off;
    int                 w_sum;

    // Rotate so bit 0 is the first candidate after the last winner. Doubling
    // the vector lets a plain right shift implement the wrap-around; a start
    // offset of N_REQ (last winner N_REQ-1) selects the upper copy unchanged.
    assign w_dbl   = {req_i, req_i};
    assign w_start = {1'b0, last_gnt_i} + 1'b1;
    assign w_rot   = N_REQ'(w_dbl >> w_start);

    always_comb begin
        valid_o = |req_i;
        // Lowest set bit of the rotated vector has the highest priority.
        w_off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i;
            end
        end
        // Undo the rotation; the sum never exceeds 2*N_REQ-1, so one wrap suffices.
        w_sum = int'(w_start) + w_off;
        if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
        end
        winner_o = ID_W'(w_sum);
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module : uart_tx_arbiter
// Brief  : Shares one UART transmitter among N_REQ byte requesters using
//          round-robin arbitration. Each transfer is sequenced as grant,
//          one-cycle enable pulse, wait for transmitter busy, wait for idle.
//          Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
// Ports  : clk      in  1        system clock, rising edge
//          res      in  1        asynchronous reset, active-high
//          req_i    in  N_REQ    per-requester request, held with data until ack
//          data_i   in  8*N_REQ  byte of requester k on bits [8k+7:8k]
//          ack_o    out N_REQ    one-cycle pulse, byte of requester k latched
//          done_o   out 1        one-cycle pulse, granted byte finished
//          gnt_id_o out 3        index of current/last granted requester
//          busy_o   out 1        high from grant until done/abort
//          tx_data  out 8        to transmitter data_in
//          tx_en    out 1        to transmitter en_data_in, one-cycle pulse
//          tx_rdy   in  1        from transmitter rdy, high = idle
//          err_o    out 1        watchdog abort pulse (0 without the macro)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [BYTE_W*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    done_o,
    output logic [ID_W-1:0]         gnt_id_o,
    output logic                    busy_o,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_en,
    input  logic                    tx_rdy,
    output logic                    err_o
);

    state_t              state_q,    state_d;
    logic [N_REQ-1:0]    ack_q,      ack_d;
    logic                done_q,     done_d;
    logic                busy_q,     busy_d;
    logic                tx_en_q,    tx_en_d;
    logic [BYTE_W-1:0]   data_q,     data_d;
    logic [ID_W-1:0]     gnt_q,      gnt_d;
    logic [ID_W-1:0]     last_gnt_q, last_gnt_d;

    logic                w_pick_valid;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_timeout;

    uart_rr_pick #(
        .N_REQ      (N_REQ)
    ) u_pick (
        .req_i      (req_i),
        .last_gnt_i (last_gnt_q),
        .valid_o    (w_pick_valid),
        .winner_o   (w_pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        tx_en_d    = 1'b0;
        data_d     = data_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;

        case (state_q)
            ST_IDLE: begin
                // A busy transmitter in IDLE is driven by someone else: hold off.
                if (w_pick_valid && tx_rdy) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        if (w_pick_idx == ID_W'(k)) begin
                            ack_d[k] = 1'b1;
                            data_d   = data_i[k*BYTE_W +: BYTE_W];
                        end
                    end
                    gnt_d      = w_pick_idx;
                    last_gnt_d = w_pick_idx;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_en_d = 1'b1;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_rdy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_rdy) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog abort: back to IDLE without done; last_gnt keeps the
        // aborted requester so it is not favoured again.
        if (w_timeout) begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            data_q     <= '0;
            gnt_q      <= '0;
            last_gnt_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_en_q    <= tx_en_d;
            data_q     <= data_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q;
    logic        w_in_wait;

    assign w_in_wait = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
    // wdog_q counts completed cycles in the current wait state, so the value
    // TIMEOUT_CYC-1 marks the TIMEOUT_CYC-th cycle spent there.
    assign w_timeout = w_in_wait && (wdog_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        wdog_d = '0;
        if (w_in_wait && (state_d == state_q)) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= w_timeout;
        end
    end

    assign err_o = err_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign w_timeout          = 1'b0;
    assign err_o              = 1'b0;
`endif

    assign ack_o    = ack_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = data_q;
    assign gnt_id_o = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench for uart_tx_arbiter with a behavioural
//          transmitter model and a byte-order scoreboard on tx_data.
//          Honours UART_ARB_TIMEOUT_EN for the watchdog scenario.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          res;
    logic [N-1:0]  req_i;
    logic [8*N-1:0] data_i;
    logic [N-1:0]  ack_o;
    logic          done_o;
    logic [2:0]    gnt_id_o;
    logic          busy_o;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_rdy;
    logic          err_o;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    exp_q[$];

    // Transmitter model controls
    logic          m_rdy;
    logic          m_active;
    int            m_cnt;
    logic          ext_busy;
    logic          stuck;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk      (clk),
        .res      (res),
        .req_i    (req_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .done_o   (done_o),
        .gnt_id_o (gnt_id_o),
        .busy_o   (busy_o),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_rdy   (tx_rdy),
        .err_o    (err_o)
    );

    // Transmitter: rdy drops 2 clks after en, returns ~100 clks after en.
    always @(posedge clk or posedge res) begin
        if (res) begin
            m_rdy    <= 1'b1;
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (tx_en) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 1) m_rdy <= 1'b0;
            if (m_cnt == 99 && !stuck) begin
                m_rdy    <= 1'b1;
                m_active <= 1'b0;
            end
        end
    end

    assign tx_rdy = m_rdy & ~ext_busy;

    // Scoreboard and one-hot monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_order: tx_data=%h with no byte expected", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    failures++;
                    $display("FAIL sb_order: tx_data=%h required %h", tx_data, e);
                end
            end
        end
        if (ack_o !== '0) begin
            checks++;
            if ($countones(ack_o) != 1) begin
                failures++;
                $display("FAIL ack_onehot: ack_o=%b required exactly one bit", ack_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res      = 1'b1;
        req_i    = '0;
        stuck    = 1'b0;
        ext_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (ack_o !== '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (done_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        req_i = '0; stuck = 1'b0; ext_busy = 1'b0;
        data_i = '0;
        #3;
        checks++;
        if ({ack_o, done_o, gnt_id_o, busy_o, tx_data, tx_en, err_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b done=%b gnt=%0d busy=%b data=%h en=%b err=%b required all 0",
                     ack_o, done_o, gnt_id_o, busy_o, tx_data, tx_en, err_o);
        end
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int extra;
        do_reset();
        data_i = 32'h55_0a_33_44;
        req_i  = 4'b0100;
        exp_q.push_back(8'h0a);
        tick();
        checks++;
        if (ack_o !== 4'b0100 || gnt_id_o !== 3'd2 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_ack: ack=%b gnt=%0d busy=%b required 0100/2/1", ack_o, gnt_id_o, busy_o);
        end
        req_i = '0;
        tick();
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h0a || ack_o !== '0) begin
            failures++;
            $display("FAIL single_en: en=%b data=%h ack=%b required 1/0a/0000", tx_en, tx_data, ack_o);
        end
        tick();
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h0a) begin
            failures++;
            $display("FAIL single_en_pulse: en=%b data=%h required 0/0a", tx_en, tx_data);
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_done: done_o=%b required pulse within 300 clks", done_o);
        end
        extra = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (done_o === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || busy_o !== 1'b0 || tx_data !== 8'h0a) begin
            failures++;
            $display("FAIL single_after: extra_done=%0d busy=%b data=%h required 0/0/0a", extra, busy_o, tx_data);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        data_i = 32'h13_12_11_10;
        req_i  = 4'b1111;
        foreach (order[i]) exp_q.push_back(8'h10 + 8'(order[i]));
        for (int g = 0; g < 5; g++) begin
            wait_ack(300, ok);
            checks++;
            if (!ok || ack_o !== (4'b0001 << order[g]) || gnt_id_o !== 3'(order[g])) begin
                failures++;
                $display("FAIL rr_grant%0d: ack=%b gnt=%0d required ack=%b gnt=%0d",
                         g, ack_o, gnt_id_o, 4'b0001 << order[g], order[g]);
            end
            if (g == 4) req_i = '0;
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_last_done: done_o=%b required pulse within 300 clks", done_o);
        end
    endtask

    task automatic test_hold_off();
        bit ok;
        int seen;
        do_reset();
        ext_busy = 1'b1;
        data_i   = 32'h00_00_00_5a;
        req_i    = 4'b0001;
        seen     = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (ack_o !== '0 || tx_en !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL holdoff_idle: active_cycles=%0d busy=%b required 0/0", seen, busy_o);
        end
        exp_q.push_back(8'h5a);
        ext_busy = 1'b0;
        tick();
        checks++;
        if (ack_o !== 4'b0001) begin
            failures++;
            $display("FAIL holdoff_release: ack=%b required 0001", ack_o);
        end
        req_i = '0;
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL holdoff_done: done_o=%b required pulse within 300 clks", done_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        data_i = 32'h00_33_00_00;
        req_i  = 4'b0100;
        exp_q.push_back(8'h33);
        wait_ack(10, ok);
        req_i = '0;
        for (int n = 0; n < 20 && tx_rdy === 1'b1; n++) tick();
        repeat (3) tick();
        checks++;
        if (!ok || busy_o !== 1'b1 || tx_rdy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_setup: ack_seen=%0d busy=%b rdy=%b required 1/1/0", ok, busy_o, tx_rdy);
        end
        res = 1'b1;
        #1;
        checks++;
        if ({ack_o, done_o, gnt_id_o, busy_o, tx_data, tx_en, err_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: ack=%b done=%b gnt=%0d busy=%b data=%h en=%b err=%b required all 0",
                     ack_o, done_o, gnt_id_o, busy_o, tx_data, tx_en, err_o);
        end
        repeat (2) @(posedge clk);
        #1;
        res    = 1'b0;
        data_i = 32'h00_00_77_00;
        req_i  = 4'b0010;
        exp_q.push_back(8'h77);
        tick();
        checks++;
        if (ack_o !== 4'b0010 || gnt_id_o !== 3'd1) begin
            failures++;
            $display("FAIL midreset_regrant: ack=%b gnt=%0d required 0010/1", ack_o, gnt_id_o);
        end
        req_i = '0;
        wait_done(300, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int done_seen;
        int err_seen;
        do_reset();
        stuck  = 1'b1;
        data_i = 32'h00_00_00_c3;
        req_i  = 4'b0001;
        exp_q.push_back(8'hc3);
        wait_ack(10, ok);
        req_i     = '0;
        done_seen = 0;
        err_seen  = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int n = 0; n < 300 && err_seen == 0; n++) begin
            tick();
            if (done_o === 1'b1) done_seen++;
            if (err_o === 1'b1) err_seen++;
        end
        checks++;
        if (err_seen != 1 || done_seen != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: err_pulses=%0d done_pulses=%0d busy=%b required 1/0/0",
                     err_seen, done_seen, busy_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: err_o=%b required 0 one clk after pulse", err_o);
        end
`else
        for (int n = 0; n < 300; n++) begin
            tick();
            if (done_o === 1'b1) done_seen++;
            if (err_o !== 1'b0) err_seen++;
        end
        checks++;
        if (err_seen != 0 || done_seen != 0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout: err_cycles=%0d done_pulses=%0d busy=%b required 0/0/1",
                     err_seen, done_seen, busy_o);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_off();
        test_reset_mid();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
